// File: rtl/pong_match_ctrl.sv
// Match-level sequencer for Pong: owns scores, serve timing/direction and game over,
// and drives the run/freeze enable and ball-reset strobe back into the field controller.
module pong_match_ctrl #(
  parameter int WIN_SCORE    = 9,
  parameter int SERVE_FRAMES = 60,
  parameter int HOLD_FRAMES  = 90
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       frame_tick,
  input  logic       p1_point,
  input  logic       p2_point,
  output logic       run,
  output logic       ball_reset,
  output logic       serve_dir,
  output logic [3:0] p1_score,
  output logic [3:0] p2_score,
  output logic [1:0] winner,
  output logic       done
);

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] SERVE      = 3'd1;
  localparam logic [2:0] PLAY       = 3'd2;
  localparam logic [2:0] HOLD       = 3'd3;
  localparam logic [2:0] MATCH_OVER = 3'd4;

  localparam logic [3:0] WIN        = 4'(WIN_SCORE);
  localparam logic [7:0] SERVE_LAST = 8'(SERVE_FRAMES - 1);
  localparam logic [7:0] HOLD_LAST  = 8'(HOLD_FRAMES - 1);

  logic [2:0] state;
  logic [7:0] fcnt;
  logic       start_q;
  logic       start_edge;

  // Scores stop at the winning value; the hold phase ends the match before another point.
  function automatic logic [3:0] sat_inc(input logic [3:0] s);
    return (s >= WIN) ? WIN : s + 4'd1;
  endfunction

  assign start_edge = start & ~start_q;
  assign run        = (state == PLAY);
  assign done       = (state == MATCH_OVER);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      fcnt       <= 8'd0;
      start_q    <= 1'b1;
      ball_reset <= 1'b0;
      serve_dir  <= 1'b1;
      p1_score   <= 4'd0;
      p2_score   <= 4'd0;
      winner     <= 2'b00;
    end else begin
      start_q    <= start;
      ball_reset <= 1'b0;
      case (state)
        IDLE, MATCH_OVER: begin
          if (start_edge) begin
            p1_score   <= 4'd0;
            p2_score   <= 4'd0;
            winner     <= 2'b00;
            serve_dir  <= 1'b1;
            ball_reset <= 1'b1;
            fcnt       <= 8'd0;
            state      <= SERVE;
          end
        end
        SERVE: begin
          if (frame_tick) begin
            if (fcnt == SERVE_LAST) begin
              fcnt  <= 8'd0;
              state <= PLAY;
            end else begin
              fcnt <= fcnt + 8'd1;
            end
          end
        end
        PLAY: begin
          if (p1_point | p2_point) begin
            // A simultaneous pair is treated as a dead ball: freeze, but no score.
            if (p1_point & ~p2_point) begin
              p1_score  <= sat_inc(p1_score);
              serve_dir <= 1'b0;
            end else if (p2_point & ~p1_point) begin
              p2_score  <= sat_inc(p2_score);
              serve_dir <= 1'b1;
            end
            ball_reset <= 1'b1;
            fcnt       <= 8'd0;
            state      <= HOLD;
          end
        end
        HOLD: begin
          if (frame_tick) begin
            if (fcnt == HOLD_LAST) begin
              fcnt <= 8'd0;
              if (p1_score == WIN) begin
                winner <= 2'b01;
                state  <= MATCH_OVER;
              end else if (p2_score == WIN) begin
                winner <= 2'b10;
                state  <= MATCH_OVER;
              end else begin
                state <= SERVE;
              end
            end else begin
              fcnt <= fcnt + 8'd1;
            end
          end
        end
        default: begin
          fcnt  <= 8'd0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Self-checking bench for pong_match_ctrl: directed scenarios plus a randomized run
// against a countdown-based behavioural model of the match rules.
module tb_pong_match_ctrl;

  localparam int W = 3;
  localparam int S = 4;
  localparam int H = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       frame_tick = 1'b0;
  logic       p1_point = 1'b0;
  logic       p2_point = 1'b0;
  logic       run, ball_reset, serve_dir, done;
  logic [3:0] p1_score, p2_score;
  logic [1:0] winner;

  int checks = 0;
  int errors = 0;

  pong_match_ctrl #(.WIN_SCORE(W), .SERVE_FRAMES(S), .HOLD_FRAMES(H)) dut (
    .clk(clk), .rst(rst), .start(start), .frame_tick(frame_tick),
    .p1_point(p1_point), .p2_point(p2_point), .run(run), .ball_reset(ball_reset),
    .serve_dir(serve_dir), .p1_score(p1_score), .p2_score(p2_score),
    .winner(winner), .done(done)
  );

  always #5 clk = ~clk;

  // Reference model: phase 0 idle, 1 serve, 2 play, 3 hold, 4 over; left = ticks still owed.
  int         m_phase, m_left;
  logic [3:0] m_p1, m_p2;
  logic       m_dir, m_br, m_sq;
  logic [1:0] m_win;

  task automatic model_step(input logic r, input logic s, input logic t,
                            input logic a, input logic b);
    logic edge_seen;
    if (r) begin
      m_phase = 0; m_left = 0; m_p1 = 0; m_p2 = 0;
      m_dir = 1; m_win = 0; m_br = 0; m_sq = 1;
      return;
    end
    edge_seen = s && !m_sq;
    m_sq = s;
    m_br = 0;
    if (m_phase == 0 || m_phase == 4) begin
      if (edge_seen) begin
        m_p1 = 0; m_p2 = 0; m_win = 0; m_dir = 1; m_br = 1;
        m_phase = 1; m_left = S;
      end
    end else if (m_phase == 1) begin
      if (t) begin
        m_left--;
        if (m_left == 0) m_phase = 2;
      end
    end else if (m_phase == 2) begin
      if (a && !b) begin
        m_p1 = (m_p1 == W) ? 4'(W) : m_p1 + 1; m_dir = 0;
      end else if (b && !a) begin
        m_p2 = (m_p2 == W) ? 4'(W) : m_p2 + 1; m_dir = 1;
      end
      if (a || b) begin
        m_phase = 3; m_left = H; m_br = 1;
      end
    end else begin
      if (t) begin
        m_left--;
        if (m_left == 0) begin
          if (m_p1 == W) m_win = 2'b01;
          else if (m_p2 == W) m_win = 2'b10;
          if (m_win != 0) m_phase = 4;
          else begin m_phase = 1; m_left = S; end
        end
      end
    end
  endtask

  // One clock with the given inputs; outputs are sampled 1 time unit after the edge.
  task automatic cyc(input logic s, input logic t, input logic a, input logic b);
    start = s; frame_tick = t; p1_point = a; p2_point = b;
    @(posedge clk); #1;
    frame_tick = 0; p1_point = 0; p2_point = 0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(start, 1, 0, 0);
      cyc(start, 0, 0, 0);
    end
  endtask

  task automatic test_reset;
    rst = 1;
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0);
    checks++;
    if ({run, ball_reset, serve_dir, p1_score, p2_score, winner, done} !== {1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 2'b00, 1'b0}) begin
      errors++;
      $display("FAIL reset_outputs got run=%b br=%b dir=%b s=%0d/%0d win=%b done=%b", run, ball_reset, serve_dir, p1_score, p2_score, winner, done);
    end
    rst = 0;
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    checks++;
    if (ball_reset !== 1'b0 || run !== 1'b0) begin
      errors++;
      $display("FAIL held_start_no_edge br=%b run=%b expected 0/0", ball_reset, run);
    end
    cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    checks++;
    if (ball_reset !== 1'b1) begin
      errors++;
      $display("FAIL start_edge_ball_reset got %b expected 1", ball_reset);
    end
    cyc(1, 0, 0, 0);
    checks++;
    if (ball_reset !== 1'b0) begin
      errors++;
      $display("FAIL ball_reset_width got %b expected 0", ball_reset);
    end
  endtask

  task automatic test_serve;
    ticks(S - 1);
    checks++;
    if (run !== 1'b0) begin
      errors++;
      $display("FAIL serve_early got run=%b expected 0", run);
    end
    cyc(1, 1, 0, 0);
    checks++;
    if (run !== 1'b1) begin
      errors++;
      $display("FAIL serve_release got run=%b expected 1", run);
    end
  endtask

  task automatic test_single_point;
    cyc(1, 0, 0, 1);
    checks++;
    if ({p2_score, serve_dir, run, ball_reset} !== {4'd1, 1'b1, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL p2_point got s2=%0d dir=%b run=%b br=%b expected 1 1 0 1", p2_score, serve_dir, run, ball_reset);
    end
    ticks(H);
    checks++;
    if (run !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL hold_to_serve got run=%b done=%b expected 0 0", run, done);
    end
    ticks(S);
    checks++;
    if (run !== 1'b1) begin
      errors++;
      $display("FAIL serve_to_play got run=%b expected 1", run);
    end
  endtask

  task automatic test_simultaneous;
    cyc(1, 0, 1, 0);
    ticks(H + S);
    cyc(1, 0, 1, 1);
    checks++;
    if ({p1_score, p2_score, serve_dir, run, ball_reset} !== {4'd1, 4'd1, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL both_points got %0d/%0d dir=%b run=%b br=%b expected 1/1 0 0 1", p1_score, p2_score, serve_dir, run, ball_reset);
    end
    ticks(H + S);
  endtask

  task automatic test_ignored;
    cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    checks++;
    if ({run, ball_reset, p1_score, p2_score} !== {1'b1, 1'b0, 4'd1, 4'd1}) begin
      errors++;
      $display("FAIL start_in_play got run=%b br=%b %0d/%0d expected 1 0 1/1", run, ball_reset, p1_score, p2_score);
    end
    cyc(1, 0, 1, 0);
    cyc(1, 0, 1, 0);
    checks++;
    if (p1_score !== 4'd2 || run !== 1'b0) begin
      errors++;
      $display("FAIL point_in_hold got s1=%0d run=%b expected 2 0", p1_score, run);
    end
    ticks(H);
    cyc(1, 0, 1, 0);
    checks++;
    if (p1_score !== 4'd2 || run !== 1'b0) begin
      errors++;
      $display("FAIL point_in_serve got s1=%0d run=%b expected 2 0", p1_score, run);
    end
    ticks(S);
  endtask

  task automatic test_match_win;
    cyc(1, 0, 1, 0);
    ticks(H);
    checks++;
    if ({winner, done, p1_score, run} !== {2'b01, 1'b1, 4'd3, 1'b0}) begin
      errors++;
      $display("FAIL match_over got win=%b done=%b s1=%0d run=%b expected 01 1 3 0", winner, done, p1_score, run);
    end
    cyc(1, 0, 1, 0);
    ticks(S + 1);
    checks++;
    if (p1_score !== 4'd3 || done !== 1'b1) begin
      errors++;
      $display("FAIL score_held got s1=%0d done=%b expected 3 1", p1_score, done);
    end
    cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    checks++;
    if ({p1_score, p2_score, winner, done, serve_dir, ball_reset} !== {4'd0, 4'd0, 2'b00, 1'b0, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL restart got %0d/%0d win=%b done=%b dir=%b br=%b", p1_score, p2_score, winner, done, serve_dir, ball_reset);
    end
  endtask

  task automatic test_random;
    logic r, s, t, a, b;
    s = 0;
    rst = 1;
    model_step(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    rst = 0;
    for (int i = 0; i < 4000; i++) begin
      r = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 29) == 0) s = ~s;
      t = ($urandom_range(0, 2) == 0);
      a = ($urandom_range(0, 9) == 0);
      b = ($urandom_range(0, 9) == 0);
      rst = r;
      model_step(r, s, t, a, b);
      cyc(s, t, a, b);
      checks++;
      if ({run, ball_reset, serve_dir, p1_score, p2_score, winner, done} !==
          {(m_phase == 2), m_br, m_dir, m_p1, m_p2, m_win, (m_phase == 4)}) begin
        errors++;
        $display("FAIL random_cycle_%0d got run=%b br=%b dir=%b %0d/%0d win=%b done=%b expected run=%b br=%b dir=%b %0d/%0d win=%b done=%b",
                 i, run, ball_reset, serve_dir, p1_score, p2_score, winner, done,
                 (m_phase == 2), m_br, m_dir, m_p1, m_p2, m_win, (m_phase == 4));
      end
    end
    rst = 0;
  endtask

  initial begin
    test_reset();
    test_serve();
    test_single_point();
    test_simultaneous();
    test_ignored();
    test_match_win();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pong_match_ctrl.md
Name: pong_match_ctrl

Overview:
Match-level sequencer for the Pong game. Consumes per-point pulses from the VGA/game-field controller and a per-frame tick. Owns both player scores, serve timing and serve direction, and the game-over condition. Drives the run/freeze enable and ball-reset strobe back into the field controller, and the score nibbles out to the seven-segment display decoders.

Parameters:
WIN_SCORE, 9, points needed to win the match; legal range 1..15.
SERVE_FRAMES, 60, frame ticks the ball is held at centre before each serve; must be >= 1.
HOLD_FRAMES, 90, frame ticks of freeze after a point is scored; must be >= 1.

Ports:
clk  in  1  system clock, 50 MHz domain
rst  in  1  synchronous active-high reset
start  in  1  level from synchronised, debounced pushbutton; a rising edge is detected internally
frame_tick  in  1  one-clk pulse per video frame, synchronised to clk
p1_point  in  1  one-clk pulse: ball passed P2's goal, so P1 scores
p2_point  in  1  one-clk pulse: ball passed P1's goal, so P2 scores
run  out  1  1 = ball and paddles animate; 0 = frozen
ball_reset  out  1  one-clk pulse: recentre ball
serve_dir  out  1  0 = serve toward P1, 1 = serve toward P2
p1_score  out  4  P1 score, binary
p2_score  out  4  P2 score, binary
winner  out  2  00 = none, 01 = P1, 10 = P2
done  out  1  1 while in MATCH_OVER

Behaviour:
- Reset value of every output: run=0, ball_reset=0, serve_dir=1, p1_score=0, p2_score=0, winner=00, done=0. The state machine resets to IDLE, the frame counter to 0 and start_q (registered start) to 1. A start already held at reset therefore produces no edge.
- Reset is synchronous and has priority over every other input in the same cycle, in any state.
- start_edge = start & ~start_q.
- Frame counter fcnt: 8 bits. Cleared on every state entry. Increments on frame_tick only in SERVE and HOLD.
- States and transitions:
  - IDLE: run=0. On start_edge, clear both scores and winner, pulse ball_reset, set serve_dir=1, go to SERVE.
  - SERVE: run=0. When frame_tick arrives with fcnt==SERVE_FRAMES-1, go to PLAY. The delay is exactly SERVE_FRAMES ticks after entry.
  - PLAY: run=1. Point handling:
    - p1_point alone: p1_score+1, serve_dir=0, go to HOLD.
    - p2_point alone: p2_score+1, serve_dir=1, go to HOLD.
    - Both in the same cycle: no score change, serve_dir unchanged, go to HOLD.
  - HOLD: run=0. ball_reset pulses on the entry cycle. After HOLD_FRAMES ticks:
    - If either score == WIN_SCORE, set winner and go to MATCH_OVER.
    - Otherwise go to SERVE.
  - MATCH_OVER: run=0, done=1. Scores and winner are held. On start_edge, behave exactly as the IDLE start: clear, ball_reset, SERVE.
- Latency: a point pulse in cycle N gives the updated score, run=0 and ball_reset=1 in cycle N+1.
- Point pulses outside PLAY are ignored. start_edge is ignored in SERVE, PLAY and HOLD.
- Score width: a score saturates at WIN_SCORE and never wraps. The match end is detected before any further increment is possible.
- frame_tick coincident with a state entry is not counted; the counter clears on that cycle.
- ball_reset is exactly one clk wide. It is never asserted in two consecutive cycles.

Test Plan:
- Reset behaviour: rst=1 for 3 clk with start=1, then rst=0 with start held high -> state stays IDLE, all outputs at reset values, no ball_reset pulse. Release start, then raise it again -> ball_reset=1 for one clk and state=SERVE.
- Serve timing (SERVE_FRAMES=4): start edge, then frame ticks -> run rises 1 clk after the 4th tick; run stays 0 after 3 ticks.
- Single point: in PLAY, pulse p2_point -> next clk: p2_score=1, serve_dir=1, run=0, ball_reset=1. After HOLD_FRAMES ticks -> SERVE, then PLAY after SERVE_FRAMES ticks.
- Simultaneous points: p1_point and p2_point in the same clk -> scores unchanged (e.g. 3/2 stays 3/2), serve_dir unchanged, state=HOLD.
- Match win (WIN_SCORE=3): P1 scores 3 points -> after the final hold, winner=01, done=1, p1_score=3. Further p1_point pulses leave p1_score=3. A start edge gives scores 0/0, winner=00, done=0, serve_dir=1.
- Ignored inputs: p1_point during SERVE and HOLD, and a start edge during PLAY -> no score change, no state change.
